// File: rtl/gpio_regfile_v2.sv
// GPIO register file: data/tristate/mask registers, synchronised pin inputs,
// per-pin edge detection into a sticky W1C interrupt status, registered irq.
module gpio_regfile_v2 #(
    parameter int NUM_PINS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:2]          addr,
    input  logic [3:0]          wben,
    input  logic                r_wn,
    input  logic [31:0]         wdata,
    input  logic [NUM_PINS-1:0] ro_gpio_pinstate,
    output logic [31:0]         rdata,
    output logic [NUM_PINS-1:0] rf_gpio_datareg,
    output logic [NUM_PINS-1:0] rf_gpio_tristate,
    output logic [NUM_PINS-1:0] rf_gpio_interrupt_mask,
    output logic                irq
);

    localparam logic [31:0] PIN_MASK = 32'((64'd1 << NUM_PINS) - 64'd1);
    localparam int          CW       = 3;
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SYNC_STAGES + 1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_TRI    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_PIN    = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_POL    = 3'd5;
    localparam logic [2:0] A_BOTH   = 3'd6;

    // Registers are held 32 bits wide; bits at and above NUM_PINS are forced
    // to 0 by PIN_MASK and trimmed away in synthesis.
    logic [31:0] data_q, data_d, tri_q, tri_d, mask_q, mask_d;
    logic [31:0] status_q, status_d, pol_q, pol_d, both_q, both_d;
    logic [31:0] prev_q, prev_d, rdata_q, rdata_d;
    logic [SYNC_STAGES-1:0][31:0] sync_q, sync_d;
    logic [CW-1:0] settle_q, settle_d;
    logic          irq_q, irq_d;

    logic [31:0] byte_en, wr_bits, wd, sync_out, rise, fall, evt;

    always_comb begin
        byte_en = '0;
        for (int i = 0; i < 4; i++)
            byte_en[8*i +: 8] = {8{wben[i] & ~r_wn}};
        wr_bits = byte_en & PIN_MASK;
        wd      = wdata & wr_bits;

        sync_d[0] = 32'(ro_gpio_pinstate);
        for (int k = 1; k < SYNC_STAGES; k++)
            sync_d[k] = sync_q[k-1];
        sync_out = sync_q[SYNC_STAGES-1];
        prev_d   = sync_out;

        rise = sync_out & ~prev_q;
        fall = ~sync_out & prev_q;
        // Events are held off until the synchroniser has flushed post-reset
        // contents, so pads already high at reset raise nothing.
        evt  = ((both_q & (rise | fall)) | (~both_q & pol_q & rise) |
                (~both_q & ~pol_q & fall)) & PIN_MASK;
        if (settle_q != '0)
            evt = '0;
        settle_d = (settle_q != '0) ? settle_q - 1'b1 : settle_q;

        data_d = (addr == A_DATA) ? ((data_q & ~wr_bits) | wd) : data_q;
        tri_d  = (addr == A_TRI)  ? ((tri_q  & ~wr_bits) | wd) : tri_q;
        mask_d = (addr == A_MASK) ? ((mask_q & ~wr_bits) | wd) : mask_q;
        pol_d  = (addr == A_POL)  ? ((pol_q  & ~wr_bits) | wd) : pol_q;
        both_d = (addr == A_BOTH) ? ((both_q & ~wr_bits) | wd) : both_q;
        // A new event beats a same-cycle clear.
        status_d = (status_q & ~((addr == A_STATUS) ? wd : 32'd0)) | evt;

        irq_d = |(status_q & mask_q & PIN_MASK);

        rdata_d = rdata_q;
        if (r_wn) begin
            case (addr)
                A_DATA:   rdata_d = data_q;
                A_TRI:    rdata_d = tri_q;
                A_MASK:   rdata_d = mask_q;
                A_PIN:    rdata_d = sync_out & PIN_MASK;
                A_STATUS: rdata_d = status_q;
                A_POL:    rdata_d = pol_q;
                A_BOTH:   rdata_d = both_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            tri_q    <= '0;
            mask_q   <= '0;
            status_q <= '0;
            pol_q    <= '0;
            both_q   <= '0;
            prev_q   <= '0;
            sync_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            settle_q <= SETTLE_INIT;
        end else begin
            data_q   <= data_d;
            tri_q    <= tri_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            pol_q    <= pol_d;
            both_q   <= both_d;
            prev_q   <= prev_d;
            sync_q   <= sync_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            settle_q <= settle_d;
        end
    end

    assign rdata                  = rdata_q;
    assign irq                    = irq_q;
    assign rf_gpio_datareg        = data_q[NUM_PINS-1:0];
    assign rf_gpio_tristate       = tri_q[NUM_PINS-1:0];
    assign rf_gpio_interrupt_mask = mask_q[NUM_PINS-1:0];

endmodule

// File: tb/tb_gpio_regfile_v2.sv
// Bench for gpio_regfile_v2: a 16-pin and an 8-pin instance share one bus;
// read expectations are queued and checked by an independent monitor.
module tb_gpio_regfile_v2;

    logic        clk, reset, r_wn;
    logic [4:2]  addr;
    logic [3:0]  wben;
    logic [31:0] wdata;
    logic [15:0] pad16;
    logic [7:0]  pad8;
    logic [31:0] rdata16, rdata8;
    logic [15:0] dreg16, tri16, msk16;
    logic [7:0]  dreg8, tri8, msk8;
    logic        irq16, irq8;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        bit          sel8;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    logic rd_seen;

    gpio_regfile_v2 #(.NUM_PINS(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .reset(reset), .addr(addr), .wben(wben), .r_wn(r_wn),
        .wdata(wdata), .ro_gpio_pinstate(pad16), .rdata(rdata16),
        .rf_gpio_datareg(dreg16), .rf_gpio_tristate(tri16),
        .rf_gpio_interrupt_mask(msk16), .irq(irq16));

    gpio_regfile_v2 #(.NUM_PINS(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .addr(addr), .wben(wben), .r_wn(r_wn),
        .wdata(wdata), .ro_gpio_pinstate(pad8), .rdata(rdata8),
        .rf_gpio_datareg(dreg8), .rf_gpio_tristate(tri8),
        .rf_gpio_interrupt_mask(msk8), .irq(irq8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a read issued before an edge presents rdata after that edge.
    always @(posedge clk) rd_seen <= r_wn;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_read got=%h required=<no read queued>", rdata16);
            end else begin
                exp_t e;
                logic [31:0] got;
                e   = sb.pop_front();
                got = e.sel8 ? rdata8 : rdata16;
                n_chk++;
                if (got !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s got=%h required=%h", e.name, got, e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] wb, input logic [31:0] d);
        addr = a; wben = wb; wdata = d; r_wn = 1'b0;
        tick(1);
        wben = '0;
    endtask

    task automatic rd(input logic [2:0] a, input bit s8, input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.sel8 = s8; e.exp = exp;
        sb.push_back(e);
        addr = a; r_wn = 1'b1; wben = '0;
        tick(1);
        r_wn = 1'b0;
    endtask

    initial begin
        reset = 1'b1; r_wn = 1'b0; addr = '0; wben = '0; wdata = '0;
        pad16 = '0; pad8 = '0;
        tick(2);
        reset = 1'b0;

        chk("rst_datareg", 32'(dreg16), 32'h0);
        chk("rst_tristate", 32'(tri16), 32'h0);
        chk("rst_mask", 32'(msk16), 32'h0);
        chk("rst_irq", 32'(irq16), 32'h0);
        for (int a = 0; a < 8; a++)
            rd(3'(a), 1'b0, $sformatf("rst_rd%0d", a), 32'h0);

        // Pads high through reset must not raise status.
        pad16 = 16'hFFFF; pad8 = 8'hFF;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        rd(3'd4, 1'b0, "settle_status", 32'h0);
        rd(3'd3, 1'b0, "pinstate", 32'h0000FFFF);
        pad16 = '0; pad8 = '0;
        tick(4);
        rd(3'd4, 1'b0, "fall_default", 32'h0000FFFF);
        wr(3'd4, 4'hF, 32'hFFFFFFFF);
        rd(3'd4, 1'b0, "w1c_all", 32'h0);

        // Byte-lane writes.
        wr(3'd0, 4'b0001, 32'hFFFF9249);
        chk("wben_b0", 32'(dreg16), 32'h0049);
        wr(3'd0, 4'b0010, 32'hFFFF9249);
        chk("wben_b1", 32'(dreg16), 32'h9249);
        wr(3'd0, 4'b0000, 32'h0);
        chk("wben_none", 32'(dreg16), 32'h9249);
        addr = 3'd0; wben = 4'hF; wdata = 32'h0; r_wn = 1'b1;
        begin
            exp_t e;
            e.name = "read_no_write"; e.sel8 = 1'b0; e.exp = 32'h9249;
            sb.push_back(e);
        end
        tick(1);
        r_wn = 1'b0; wben = '0;
        chk("rwn1_unchanged", 32'(dreg16), 32'h9249);

        // Rising edge on pin 0: status 3 edges after sampling, irq one later.
        wr(3'd5, 4'hF, 32'h1);
        wr(3'd2, 4'hF, 32'h1);
        pad16[0] = 1'b1;
        rd(3'd4, 1'b0, "lat_e0", 32'h0);
        rd(3'd4, 1'b0, "lat_e1", 32'h0);
        rd(3'd4, 1'b0, "lat_e2", 32'h0);
        chk("irq_early", 32'(irq16), 32'h0);
        rd(3'd4, 1'b0, "lat_e3", 32'h1);
        chk("irq_set", 32'(irq16), 32'h1);
        wr(3'd4, 4'h1, 32'h1);
        tick(1);
        chk("irq_clr", 32'(irq16), 32'h0);
        rd(3'd4, 1'b0, "st_clr", 32'h0);

        // Both edges on pin 1, unmasked then masked.
        wr(3'd6, 4'hF, 32'h2);
        pad16[1] = 1'b1;
        tick(3);
        rd(3'd4, 1'b0, "both_rise", 32'h2);
        pad16[1] = 1'b0;
        wr(3'd4, 4'hF, 32'h2);
        rd(3'd4, 1'b0, "both_clr", 32'h0);
        tick(1);
        rd(3'd4, 1'b0, "both_fall", 32'h2);
        chk("irq_masked_off", 32'(irq16), 32'h0);
        wr(3'd2, 4'hF, 32'h3);
        tick(1);
        chk("irq_unmask", 32'(irq16), 32'h1);
        wr(3'd2, 4'hF, 32'h1);
        tick(1);
        chk("irq_remask", 32'(irq16), 32'h0);
        rd(3'd4, 1'b0, "st_kept", 32'h2);
        wr(3'd4, 4'hF, 32'h2);

        // Same-cycle event and clear on bit 0: set wins.
        pad16[0] = 1'b0;
        tick(4);
        pad16[0] = 1'b1;
        tick(2);
        wr(3'd4, 4'hF, 32'h1);
        rd(3'd4, 1'b0, "set_wins", 32'h1);

        // Narrow instance truncates; reset beats a concurrent write.
        wr(3'd1, 4'hF, 32'hFFFFFFFF);
        rd(3'd1, 1'b1, "tri8_rd", 32'h000000FF);
        rd(3'd1, 1'b0, "tri16_rd", 32'h0000FFFF);
        rd(3'd7, 1'b0, "reserved_rd", 32'h0);
        addr = 3'd1; wben = 4'hF; wdata = 32'hFFFFFFFF; r_wn = 1'b0; reset = 1'b1;
        tick(1);
        reset = 1'b0; wben = '0;
        chk("tri8_rst", 32'(tri8), 32'h0);
        rd(3'd1, 1'b1, "tri8_rst_rd", 32'h0);

        tick(2);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain got=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_regfile_v2.md
Name: gpio_regfile_v2

Overview:
Parametrised successor to the team's 16-pin GPIO register file: bus-accessible data, tristate and interrupt-mask registers for NUM_PINS pins. Adds an input synchroniser, per-pin edge detection with selectable polarity, a sticky write-1-to-clear interrupt status register and a registered interrupt output. Sits between the word-addressed peripheral bus and the pad ring.

Parameters:
NUM_PINS, 16, number of GPIO pins (1..32); register bits at and above NUM_PINS read 0 and ignore writes.
SYNC_STAGES, 2, flops in the pin-input synchroniser (2..4).

Ports:
clk  input  1  single clock; all state on rising edge.
reset  input  1  synchronous, active-high reset.
addr  input  3 [4:2]  word address of the register.
wben  input  4  byte write enables; wben[i] qualifies wdata[8i+7:8i].
r_wn  input  1  1 = read cycle, 0 = write cycle.
wdata  input  32  write data.
ro_gpio_pinstate  input  NUM_PINS  raw, asynchronous pad inputs.
rdata  output  32  registered read data.
rf_gpio_datareg  output  NUM_PINS  output data register.
rf_gpio_tristate  output  NUM_PINS  output-enable register (1 = drive).
rf_gpio_interrupt_mask  output  NUM_PINS  interrupt enable per pin.
irq  output  1  registered interrupt request.

Behaviour:
- Address map, addr[4:2]: 0 DATA rw; 1 TRISTATE rw; 2 INT_MASK rw; 3 PINSTATE ro (synchronised pins); 4 INT_STATUS w1c; 5 EDGE_POL rw (1 = rising, 0 = falling); 6 EDGE_BOTH rw (1 = both edges, overrides EDGE_POL); 7 reserved: reads 0, writes ignored.
- Writes: only when r_wn=0. A register updates at the clock edge, byte by byte, per wben. wben=0 is a no-op. Writes to PINSTATE are ignored.
- Reads: when r_wn=1, rdata <= zero-extended register[addr] at the clock edge (1-cycle latency). When r_wn=0, rdata holds its last value.
- Reset: every register, rdata, irq, synchroniser flops and the edge-history flop go to 0. The settle counter loads SYNC_STAGES+1.
- Synchroniser: SYNC_STAGES flop chain. PINSTATE reflects a pad change SYNC_STAGES edges after it is sampled.
- Edge detect: prev <= sync_out every cycle. rise = sync_out & ~prev; fall = ~sync_out & prev. A pin event is (EDGE_BOTH ? rise|fall : EDGE_POL ? rise : fall).
- Settle counter: decrements to 0 after reset. Events are suppressed while it is non-zero, so pads high at reset do not cause spurious status.
- INT_STATUS: a bit sets on its pin event, independent of the mask. Writing 1 to a bit (enabled byte) clears it. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq <= |(INT_STATUS & INT_MASK & pin_mask). It is registered, 1 cycle after status/mask changes. Masking a pending bit drops irq next cycle; the status bit remains set.
- Event latency: status sets SYNC_STAGES+1 edges after the pad is sampled; irq follows 1 edge later.
- Reset asserted mid-operation wins over any concurrent write or event in that cycle.
- Reading INT_STATUS does not clear it.

Test Plan:
- Reset, then read addr 0..7 -> rdata=0 for every address; irq=0; all rf_* outputs 0. With pads=16'hFFFF held through reset -> INT_STATUS stays 0.
- r_wn=0, addr=0, wdata=32'hFFFF9249: wben=4'b0001 -> datareg=16'h0049; then wben=4'b0010 -> 16'h9249. Same write with r_wn=1 -> datareg unchanged.
- EDGE_POL=16'h0001, INT_MASK=16'h0001; pad0 0->1 -> INT_STATUS=16'h0001 at SYNC_STAGES+1 edges after sampling, irq=1 one edge later. Write 16'h0001 to INT_STATUS -> status 0, irq 0 next edge.
- EDGE_BOTH=16'h0002; pulse pad1 high for 4 cycles -> two events. INT_MASK=0 -> status bit 1 set, irq stays 0; then set INT_MASK=16'h0002 -> irq=1 next edge.
- Same-cycle pin event and W1C on bit 0 -> bit 0 remains 1.
- NUM_PINS=8: write 32'hFFFFFFFF to TRISTATE with wben=4'hF -> read back 32'h000000FF; assert reset mid-write -> value 0.
